// File: rtl/decode_hazard_tracker.sv
// -----------------------------------------------------------------------------
// decode_hazard_tracker
//
// Tracks the destination registers of instructions that have left decode but
// not yet retired, and from that table derives:
//   * registered per-operand forwarding selects for the EX operand muxes,
//   * a combinational load-use stall for fetch/decode,
//   * a saturating count of stall cycles.
//
// The table is a DEPTH-entry shift register of {valid, rd, type}; entry 0 is
// the youngest in-flight instruction. A forwarding select of k+1 means
// "take the result of the producer in entry k", 0 means "use the register
// file".
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   asynchronous active-low reset
//   advance    in   pipeline moves this cycle
//   flush      in   squash younger instructions
//   dec_valid  in   decode holds a real instruction
//   rs1_sel    in   source 1 register address
//   rs2_sel    in   source 2 register address
//   rs1_used   in   source 1 is actually read
//   rs2_used   in   source 2 is actually read
//   rd_in      in   destination register of the decoded instruction
//   type_in    in   0=idle, 1=alu, 2=load, 3=store
//   stall      out  combinational load-use stall
//   mux1_sel   out  registered forwarding select for operand 1
//   mux2_sel   out  registered forwarding select for operand 2
//   out_valid  out  registered: instruction issued to EX is real
//   rs1_type   out  registered type of operand-1 producer (0 if none)
//   rs2_type   out  registered type of operand-2 producer (0 if none)
//   stall_cnt  out  saturating count of advancing stall cycles
// -----------------------------------------------------------------------------
module decode_hazard_tracker #(
    parameter int XLEN        = 64,
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 4,
    parameter int SELW        = 3,
    parameter int LOAD_READY  = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              flush,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] rs1_sel,
    input  logic [REG_AW-1:0] rs2_sel,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [1:0]        type_in,
    output logic              stall,
    output logic [SELW-1:0]   mux1_sel,
    output logic [SELW-1:0]   mux2_sel,
    output logic              out_valid,
    output logic [1:0]        rs1_type,
    output logic [1:0]        rs2_type,
    output logic [XLEN-1:0]   stall_cnt
);

    typedef enum logic [1:0] {
        TYPE_IDLE  = 2'd0,
        TYPE_ALU   = 2'd1,
        TYPE_LOAD  = 2'd2,
        TYPE_STORE = 2'd3
    } op_type_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        op_type_e          typ;
    } entry_t;

    typedef struct packed {
        logic            hit;
        logic [SELW-1:0] sel;
        op_type_e        typ;
    } match_t;

    entry_t [DEPTH-1:0] tbl_q;
    entry_t [DEPTH-1:0] tbl_d;

    match_t m1;
    match_t m2;
    logic   hazard;
    logic   issue;

    // An entry produces a register value only for alu/load with a non-zero rd.
    function automatic logic is_writing(input entry_t e);
        return e.valid && (e.typ == TYPE_ALU || e.typ == TYPE_LOAD) && (e.rd != '0);
    endfunction

    function automatic match_t find_producer(
        input logic               used,
        input logic [REG_AW-1:0]  src,
        input entry_t [DEPTH-1:0] tbl
    );
        match_t m;
        m = '{hit: 1'b0, sel: '0, typ: TYPE_IDLE};
        if (used && src != '0) begin
            // Scan oldest to youngest so the youngest producer is the last writer.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (is_writing(tbl[k]) && tbl[k].rd == src) begin
                    m.hit = 1'b1;
                    m.sel = SELW'(k + 1);
                    m.typ = tbl[k].typ;
                end
            end
        end
        return m;
    endfunction

    // A load is forwardable only once it has travelled LOAD_READY stages.
    function automatic logic load_too_young(input match_t m);
        return m.hit && (m.typ == TYPE_LOAD) && (int'(m.sel) < LOAD_READY);
    endfunction

    always_comb begin
        m1     = find_producer(rs1_used, rs1_sel, tbl_q);
        m2     = find_producer(rs2_used, rs2_sel, tbl_q);
        hazard = load_too_young(m1) || load_too_young(m2);
    end

    // Flush takes priority: a squashed cycle never stalls.
    assign stall = dec_valid && hazard && !flush;
    assign issue = dec_valid && !stall;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        tbl_d = tbl_q;
        if (advance) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                tbl_d[k] = tbl_q[k - 1];
            end
            tbl_d[0] = '{valid: issue && !flush, rd: rd_in, typ: op_type_e'(type_in)};
        end
        // Squash applies to the post-shift table, with or without advance.
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k < FLUSH_DEPTH) begin
                    tbl_d[k].valid = 1'b0;
                end
            end
        end
    end

    // NOTE: the table is only DEPTH small entries, so every field is reset
    // rather than just the valid bits; downstream never sees stale rd/type.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its sources.
            tbl_q <= tbl_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            mux1_sel  <= '0;
            mux2_sel  <= '0;
            rs1_type  <= '0;
            rs2_type  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            mux1_sel  <= '0;
            mux2_sel  <= '0;
            rs1_type  <= '0;
            rs2_type  <= '0;
        end else if (advance) begin
            out_valid <= issue;
            mux1_sel  <= issue ? m1.sel : '0;
            mux2_sel  <= issue ? m2.sel : '0;
            rs1_type  <= issue ? m1.typ : TYPE_IDLE;
            rs2_type  <= issue ? m2.typ : TYPE_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && advance && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_hazard_tracker.sv
// -----------------------------------------------------------------------------
// tb_decode_hazard_tracker
//
// Directed scenarios followed by random traffic, all compared against a
// reference model that keeps the in-flight instructions as a queue (youngest
// at the front) and searches it for producers.
// -----------------------------------------------------------------------------
module tb_decode_hazard_tracker;

    localparam int XLEN        = 4;
    localparam int REG_AW      = 5;
    localparam int DEPTH       = 4;
    localparam int SELW        = 3;
    localparam int LOAD_READY  = 2;
    localparam int FLUSH_DEPTH = 2;
    localparam int CNT_MAX     = (1 << XLEN) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              advance;
    logic              flush;
    logic              dec_valid;
    logic [REG_AW-1:0] rs1_sel;
    logic [REG_AW-1:0] rs2_sel;
    logic              rs1_used;
    logic              rs2_used;
    logic [REG_AW-1:0] rd_in;
    logic [1:0]        type_in;
    logic              stall;
    logic [SELW-1:0]   mux1_sel;
    logic [SELW-1:0]   mux2_sel;
    logic              out_valid;
    logic [1:0]        rs1_type;
    logic [1:0]        rs2_type;
    logic [XLEN-1:0]   stall_cnt;

    decode_hazard_tracker #(
        .XLEN        (XLEN),
        .REG_AW      (REG_AW),
        .DEPTH       (DEPTH),
        .SELW        (SELW),
        .LOAD_READY  (LOAD_READY),
        .FLUSH_DEPTH (FLUSH_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .flush     (flush),
        .dec_valid (dec_valid),
        .rs1_sel   (rs1_sel),
        .rs2_sel   (rs2_sel),
        .rs1_used  (rs1_used),
        .rs2_used  (rs2_used),
        .rd_in     (rd_in),
        .type_in   (type_in),
        .stall     (stall),
        .mux1_sel  (mux1_sel),
        .mux2_sel  (mux2_sel),
        .out_valid (out_valid),
        .rs1_type  (rs1_type),
        .rs2_type  (rs2_type),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit valid;
        int rd;
        int typ;
    } rec_t;

    rec_t fl[$];          // in-flight instructions, index 0 = youngest
    bit   m_ov;
    int   m_s1, m_s2, m_t1, m_t2;
    int   m_cnt;
    bit   last_stall;

    function automatic void model_reset();
        fl.delete();
        m_ov  = 0;
        m_s1  = 0;
        m_s2  = 0;
        m_t1  = 0;
        m_t2  = 0;
        m_cnt = 0;
    endfunction

    // Youngest writer of register src; sel is its distance+1, haz if it is a
    // load that has not yet reached LOAD_READY.
    function automatic void producer(input bit used, input int src,
                                     output int sel, output int typ, output bit haz);
        sel = 0;
        typ = 0;
        haz = 0;
        if (used && src != 0) begin
            for (int i = 0; i < fl.size(); i++) begin
                if (fl[i].valid && (fl[i].typ == 1 || fl[i].typ == 2) &&
                    fl[i].rd != 0 && fl[i].rd == src) begin
                    sel = i + 1;
                    typ = fl[i].typ;
                    haz = (typ == 2) && (sel < LOAD_READY);
                    break;
                end
            end
        end
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, "_out_valid"}, 64'(out_valid), 64'(m_ov));
        check({pfx, "_mux1_sel"},  64'(mux1_sel),  64'(m_s1));
        check({pfx, "_mux2_sel"},  64'(mux2_sel),  64'(m_s2));
        check({pfx, "_rs1_type"},  64'(rs1_type),  64'(m_t1));
        check({pfx, "_rs2_type"},  64'(rs2_type),  64'(m_t2));
        check({pfx, "_stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    endtask

    // One cycle: drive, check stall before the edge, clock, update model,
    // check registered outputs after the edge. Entered and left at posedge+1.
    task automatic step(input bit a, input bit f, input bit dv,
                        input int s1, input bit u1, input int s2, input bit u2,
                        input int rd, input int ty);
        int  c1, c2, t1, t2;
        bit  h1, h2, es;
        rec_t r;
        advance   = a;
        flush     = f;
        dec_valid = dv;
        rs1_sel   = s1[REG_AW-1:0];
        rs2_sel   = s2[REG_AW-1:0];
        rs1_used  = u1;
        rs2_used  = u2;
        rd_in     = rd[REG_AW-1:0];
        type_in   = ty[1:0];
        #1;
        producer(u1, s1, c1, t1, h1);
        producer(u2, s2, c2, t2, h2);
        es = dv && (h1 || h2) && !f;
        check("stall", 64'(stall), 64'(es));
        last_stall = stall;
        @(posedge clk);
        if (f) begin
            m_ov = 0; m_s1 = 0; m_s2 = 0; m_t1 = 0; m_t2 = 0;
        end else if (a) begin
            m_ov = dv && !es;
            m_s1 = m_ov ? c1 : 0;
            m_s2 = m_ov ? c2 : 0;
            m_t1 = m_ov ? t1 : 0;
            m_t2 = m_ov ? t2 : 0;
        end
        if (a) begin
            r.valid = dv && !es && !f;
            r.rd    = rd;
            r.typ   = ty;
            fl.push_front(r);
            if (fl.size() > DEPTH) void'(fl.pop_back());
        end
        if (f) begin
            for (int i = 0; i < FLUSH_DEPTH && i < fl.size(); i++) fl[i].valid = 0;
        end
        if (es && a && m_cnt < CNT_MAX) m_cnt++;
        #1;
        check_outputs("step");
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        advance   = 1'b0;
        flush     = 1'b0;
        dec_valid = 1'b0;
        rs1_sel   = '0;
        rs2_sel   = '0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        rd_in     = '0;
        type_in   = '0;
        #3;
        model_reset();
        check("rst_stall", 64'(stall), 64'd0);
        check_outputs("rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Idle after reset
        repeat (5) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("idle_stall", 64'(stall), 64'd0);
        check("idle_out_valid", 64'(out_valid), 64'd0);

        // ALU back-to-back: add x5,x1,x2 ; sub x6,x5,x1
        step(1, 0, 1, 1, 1, 2, 1, 5, 1);
        step(1, 0, 1, 5, 1, 1, 1, 6, 1);
        check("alu_stall", 64'(last_stall), 64'd0);
        check("alu_mux1", 64'(mux1_sel), 64'd1);
        check("alu_type1", 64'(rs1_type), 64'd1);
        check("alu_mux2", 64'(mux2_sel), 64'd0);

        // Load-use: ld x7,(x2) ; add x8,x7,x7
        step(1, 0, 1, 2, 1, 0, 0, 7, 2);
        step(1, 0, 1, 7, 1, 7, 1, 8, 1);
        check("lu_stall", 64'(last_stall), 64'd1);
        check("lu_bubble", 64'(out_valid), 64'd0);
        check("lu_cnt", 64'(stall_cnt), 64'd1);
        step(1, 0, 1, 7, 1, 7, 1, 8, 1);
        check("lu_stall_release", 64'(last_stall), 64'd0);
        check("lu_mux1", 64'(mux1_sel), 64'd2);
        check("lu_mux2", 64'(mux2_sel), 64'd2);
        check("lu_type1", 64'(rs1_type), 64'd2);
        check("lu_type2", 64'(rs2_type), 64'd2);
        check("lu_cnt_hold", 64'(stall_cnt), 64'd1);

        // Youngest wins: add x3 ; add x3 ; add x9,x3,x0
        step(1, 0, 1, 0, 0, 0, 0, 3, 1);
        step(1, 0, 1, 0, 0, 0, 0, 3, 1);
        step(1, 0, 1, 3, 1, 0, 1, 9, 1);
        check("yw_mux1", 64'(mux1_sel), 64'd1);
        check("yw_mux2", 64'(mux2_sel), 64'd0);

        // rd=x0 producer, then a reader of x0
        step(1, 0, 1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 1, 0, 1, 10, 1);
        check("x0_mux1", 64'(mux1_sel), 64'd0);
        check("x0_mux2", 64'(mux2_sel), 64'd0);
        check("x0_valid", 64'(out_valid), 64'd1);

        // Flush: ld x4 enters, alu x4 in decode squashed, then a reader of x4
        step(1, 0, 1, 0, 0, 0, 0, 4, 2);
        step(1, 1, 1, 0, 0, 0, 0, 4, 1);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        step(1, 0, 1, 4, 1, 0, 0, 11, 1);
        check("fl_reader_stall", 64'(last_stall), 64'd0);
        check("fl_reader_mux1", 64'(mux1_sel), 64'd0);
        check("fl_reader_valid", 64'(out_valid), 64'd1);

        // Flush dominates a live load-use hazard
        step(1, 0, 1, 0, 0, 0, 0, 7, 2);
        step(1, 1, 1, 7, 1, 0, 0, 12, 1);
        check("fl_dom_stall", 64'(last_stall), 64'd0);

        // Freeze: hazard present, no advance
        step(1, 0, 1, 0, 0, 0, 0, 7, 2);
        check("fz_setup_valid", 64'(out_valid), 64'd1);
        step(0, 0, 1, 7, 1, 0, 0, 12, 1);
        step(0, 0, 1, 7, 1, 0, 0, 12, 1);
        check("fz_stall", 64'(last_stall), 64'd1);
        check("fz_hold_valid", 64'(out_valid), 64'd1);
        check("fz_hold_mux1", 64'(mux1_sel), 64'd0);
        step(1, 0, 1, 7, 1, 0, 0, 12, 1);
        check("fz_adv_stall", 64'(last_stall), 64'd1);
        step(1, 0, 1, 7, 1, 0, 0, 12, 1);
        check("fz_issue_mux1", 64'(mux1_sel), 64'd2);

        // Random traffic on a small register window to provoke matches
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a stall
        step(1, 0, 1, 0, 0, 0, 0, 7, 2);
        advance   = 1'b1;
        flush     = 1'b0;
        dec_valid = 1'b1;
        rs1_sel   = 5'd7;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        #1;
        check("mr_pre_stall", 64'(stall), 64'd1);
        rst = 1'b0;
        #1;
        check("mr_stall_drop", 64'(stall), 64'd0);
        do_reset();

        // Saturation: ld x7,(x7) repeated stalls every other cycle
        repeat (44) step(1, 0, 1, 7, 1, 0, 0, 7, 2);
        check("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));
        step(1, 0, 1, 7, 1, 0, 0, 7, 2);
        check("sat_cnt_hold", 64'(stall_cnt), 64'(CNT_MAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
